// File: rtl/score_bcd_seq_if.sv
// Handshake bundle between the score accumulator (master) and score_bcd_seq (slave).
// blank_mask is present only when SCORE_BCD_BLANK_EN is defined.
interface score_bcd_seq_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;
`ifdef SCORE_BCD_BLANK_EN
  logic [DIGITS-1:0]     blank_mask;
`endif

  modport master (
    output start, bin_in,
`ifdef SCORE_BCD_BLANK_EN
    input  blank_mask,
`endif
    input  busy, done, bcd_out, overflow
  );

  modport slave (
    input  start, bin_in,
`ifdef SCORE_BCD_BLANK_EN
    output blank_mask,
`endif
    output busy, done, bcd_out, overflow
  );
endinterface

// File: rtl/score_bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter: one bit per clock, saturating overflow.
// Optional leading-zero blank mask built when SCORE_BCD_BLANK_EN is defined.
module score_bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic              clk,
  input  logic              resetN,
  score_bcd_seq_if.slave    bus
);
  localparam int DW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  // Enough digit bits to hold 2^BIN_W-1: the overflow path folds away.
  localparam bit NO_OVF = (DW >= BIN_W + (BIN_W + 2) / 3);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(BIN_W);
  localparam logic [DW-1:0]    ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [BIN_W-1:0]  sh_q, sh_d;
  logic [DW-1:0]     dig_q, dig_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DW-1:0]     bcd_q, bcd_d;
  logic              ovf_out_q, ovf_out_d;
  logic [DW-1:0]     adj;
`ifdef SCORE_BCD_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              blank_run;
`endif

  // Add-3 correction applied to every digit before it is doubled.
  always_comb begin
    adj = dig_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
    state_d   = state_q;
    sh_d      = sh_q;
    dig_d     = dig_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    ovf_out_d = ovf_out_q;
`ifdef SCORE_BCD_BLANK_EN
    blank_d   = blank_q;
    blank_run = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sh_d    = bus.bin_in;
          dig_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        dig_d = {adj[DW-2:0], sh_q[BIN_W-1]};
        sh_d  = sh_q << 1;
        // A set bit leaving the top digit means the value no longer fits.
        ovf_d = NO_OVF ? 1'b0 : (ovf_q | adj[DW-1]);
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        bcd_d     = ovf_q ? ALL_NINES : dig_q;
        ovf_out_d = ovf_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
`ifdef SCORE_BCD_BLANK_EN
        blank_d   = '0;
        blank_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
          blank_run  = blank_run & (dig_q[4*i +: 4] == 4'd0);
          blank_d[i] = blank_run;
        end
        if (ovf_q) blank_d = '0;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: every register here is a plain flop (no memory array), so all of them take the async reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= S_IDLE;
      sh_q      <= '0;
      dig_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      ovf_out_q <= 1'b0;
`ifdef SCORE_BCD_BLANK_EN
      blank_q   <= BLANK_RST;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values regardless of statement order.
      state_q   <= state_d;
      sh_q      <= sh_d;
      dig_q     <= dig_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      ovf_out_q <= ovf_out_d;
`ifdef SCORE_BCD_BLANK_EN
      blank_q   <= blank_d;
`endif
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_out_q;
`ifdef SCORE_BCD_BLANK_EN
  assign bus.blank_mask = blank_q;
`endif
endmodule

// File: tb/tb_score_bcd_seq.sv
// Directed and random checks of score_bcd_seq with 5 digits and 4 digits (saturating) instances.
module tb_score_bcd_seq;
  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  score_bcd_seq_if #(.BIN_W(16), .DIGITS(5)) bus5 ();
  score_bcd_seq_if #(.BIN_W(16), .DIGITS(4)) bus4 ();

  score_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut5 (.clk(clk), .resetN(resetN), .bus(bus5.slave));
  score_bcd_seq #(.BIN_W(16), .DIGITS(4)) dut4 (.clk(clk), .resetN(resetN), .bus(bus4.slave));

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          which;
    logic [15:0] val;
    logic [19:0] exp_bcd;
    logic        exp_ovf;
    logic [4:0]  exp_blank;
  } vec_t;

  logic [19:0] res_bcd;
  logic        res_ovf;
  logic [4:0]  res_blank;
  int          res_lat, res_busy;
  logic        res_done_next;

  // Reference conversion by repeated divide/modulo with saturation.
  function automatic logic [19:0] bcd_model(input int unsigned v, input int ndig);
    logic [19:0] r;
    int unsigned lim;
    r   = '0;
    lim = (ndig == 4) ? 9999 : 99999;
    if (v > lim) begin
      for (int d = 0; d < ndig; d++) r[4*d +: 4] = 4'h9;
    end else begin
      for (int d = 0; d < ndig; d++) begin
        r[4*d +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
    return r;
  endfunction

  task automatic run_conv(input int which, input logic [15:0] val);
    int  n;
    bit  seen;
    logic d, b;
    @(negedge clk);
    if (which == 5) begin bus5.start = 1'b1; bus5.bin_in = val; end
    else            begin bus4.start = 1'b1; bus4.bin_in = val; end
    @(posedge clk);
    #1;
    bus5.start = 1'b0;
    bus4.start = 1'b0;
    n = 0; seen = 0; res_busy = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      d = (which == 5) ? bus5.done : bus4.done;
      b = (which == 5) ? bus5.busy : bus4.busy;
      if (b) res_busy++;
      if (d) seen = 1;
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    res_lat   = n - 1;
    res_bcd   = (which == 5) ? bus5.bcd_out : {4'h0, bus4.bcd_out};
    res_ovf   = (which == 5) ? bus5.overflow : bus4.overflow;
    res_blank = '0;
`ifdef SCORE_BCD_BLANK_EN
    res_blank = (which == 5) ? bus5.blank_mask : {1'b0, bus4.blank_mask};
`endif
    @(negedge clk);
    res_done_next = (which == 5) ? bus5.done : bus4.done;
  endtask

  vec_t vecs[12];

  initial begin
    int  n, dones;
    bit  seen;
    logic [19:0] exp_b;
    bit  digits_ok;
    int  which;
    logic [15:0] val;

    vecs[0]  = '{5, 16'd0,     20'h00000, 1'b0, 5'b11110};
    vecs[1]  = '{5, 16'd65535, 20'h65535, 1'b0, 5'b00000};
    vecs[2]  = '{5, 16'd1234,  20'h01234, 1'b0, 5'b10000};
    vecs[3]  = '{5, 16'd7,     20'h00007, 1'b0, 5'b11110};
    vecs[4]  = '{5, 16'd100,   20'h00100, 1'b0, 5'b11000};
    vecs[5]  = '{5, 16'd10000, 20'h10000, 1'b0, 5'b00000};
    vecs[6]  = '{4, 16'd12345, 20'h09999, 1'b1, 5'b00000};
    vecs[7]  = '{4, 16'd9999,  20'h09999, 1'b0, 5'b00000};
    vecs[8]  = '{4, 16'd10000, 20'h09999, 1'b1, 5'b00000};
    vecs[9]  = '{4, 16'd0,     20'h00000, 1'b0, 5'b01110};
    vecs[10] = '{4, 16'd65535, 20'h09999, 1'b1, 5'b00000};
    vecs[11] = '{5, 16'd4096,  20'h04096, 1'b0, 5'b10000};

    resetN = 1'b0;
    bus5.start = 1'b0; bus5.bin_in = '0;
    bus4.start = 1'b0; bus4.bin_in = '0;
    #3;
    check("rst_busy", 32'(bus5.busy), 32'd0);
    check("rst_done", 32'(bus5.done), 32'd0);
    check("rst_bcd",  32'(bus5.bcd_out), 32'd0);
    check("rst_ovf",  32'(bus5.overflow), 32'd0);
`ifdef SCORE_BCD_BLANK_EN
    check("rst_blank5", 32'(bus5.blank_mask), 32'b11110);
    check("rst_blank4", 32'(bus4.blank_mask), 32'b1110);
`endif
    repeat (2) @(negedge clk);
    resetN = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_conv(vecs[i].which, vecs[i].val);
      check($sformatf("vec%0d_bcd", i), 32'(res_bcd), 32'(vecs[i].exp_bcd));
      check($sformatf("vec%0d_ovf", i), 32'(res_ovf), 32'(vecs[i].exp_ovf));
      check($sformatf("vec%0d_lat", i), 32'(res_lat), 32'd17);
      check($sformatf("vec%0d_busy", i), 32'(res_busy), 32'd17);
      check($sformatf("vec%0d_pulse", i), 32'(res_done_next), 32'd0);
`ifdef SCORE_BCD_BLANK_EN
      if (vecs[i].which == 5)
        check($sformatf("vec%0d_blank", i), 32'(res_blank), 32'(vecs[i].exp_blank));
`endif
    end

    // start held high through a conversion while bin_in wanders
    @(negedge clk);
    bus5.start = 1'b1; bus5.bin_in = 16'd42;
    @(posedge clk);
    n = 0; seen = 0; dones = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (bus5.done) begin
        seen = 1; dones++;
        bus5.bin_in = 16'd77;
      end else begin
        bus5.bin_in = 16'($urandom_range(0, 65535));
      end
    end
    check("hold_seen", 32'(seen), 32'd1);
    check("hold_bcd", 32'(bus5.bcd_out), 32'h00042);
    @(posedge clk);
    #1;
    bus5.start = 1'b0;
    @(negedge clk);
    check("b2b_busy", 32'(bus5.busy), 32'd1);
    check("b2b_done_low", 32'(bus5.done), 32'd0);
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (bus5.done) begin seen = 1; dones++; end
    end
    check("b2b_bcd", 32'(bus5.bcd_out), 32'h00077);
    check("b2b_dones", 32'(dones), 32'd2);

    // reset in the middle of a conversion
    @(negedge clk);
    bus5.start = 1'b1; bus5.bin_in = 16'd500;
    @(posedge clk);
    #1;
    bus5.start = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_busy_before", 32'(bus5.busy), 32'd1);
    resetN = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus5.busy), 32'd0);
    check("mid_rst_bcd",  32'(bus5.bcd_out), 32'd0);
    check("mid_rst_ovf",  32'(bus5.overflow), 32'd0);
    check("mid_rst_done", 32'(bus5.done), 32'd0);
`ifdef SCORE_BCD_BLANK_EN
    check("mid_rst_blank", 32'(bus5.blank_mask), 32'b11110);
`endif
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus5.done) dones++;
    end
    check("mid_no_done", 32'(dones), 32'd0);
    run_conv(5, 16'd7);
    check("post_rst_bcd", 32'(res_bcd), 32'h00007);

    // random sweep against the divide/modulo model
    for (int i = 0; i < 1500; i++) begin
      which = ($urandom_range(0, 1) == 1) ? 5 : 4;
      val   = 16'($urandom_range(0, 65535));
      run_conv(which, val);
      exp_b = bcd_model(32'(val), which);
      check($sformatf("sweep_d%0d_%0d_bcd", which, val), 32'(res_bcd), 32'(exp_b));
      check($sformatf("sweep_d%0d_%0d_ovf", which, val), 32'(res_ovf),
            32'((which == 4) && (val > 16'd9999)));
      digits_ok = 1'b1;
      for (int d = 0; d < 5; d++) if (res_bcd[4*d +: 4] > 4'd9) digits_ok = 1'b0;
      check($sformatf("sweep_d%0d_%0d_range", which, val), 32'(digits_ok), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
